// File: rtl/sin_s11_s11_pipe_pkg.sv
// Shared constants, quadrant encoding and the table-value function for the sine pipeline.
// Build option: SIN_FULL_TABLE_EN selects a 4096-entry full-wave table instead of the quarter-wave one.
package sin_s11_pkg;

  localparam int C_PH_W  = 12;
  localparam int C_OUT_W = 12;
  localparam int C_AMP   = 2047;
  localparam int C_LAT   = 3;

`ifdef SIN_FULL_TABLE_EN
  localparam int C_ROM_AW = 12;
  localparam int C_ROM_DW = 12;
`else
  localparam int C_ROM_AW = 10;
  localparam int C_ROM_DW = 11;
`endif

  localparam logic [10:0] C_Q_PEAK = 11'(C_AMP);

  typedef enum logic [1:0] {
    Q_I   = 2'd0,
    Q_II  = 2'd1,
    Q_III = 2'd2,
    Q_IV  = 2'd3
  } quad_e;

  // round(C_AMP*sin(2*pi*k/4096)), half away from zero; valid for any k in 0..4095
  function automatic int f_sin_q(input int k);
    real v_s;
    v_s = real'(C_AMP) * $sin(2.0 * 3.14159265358979323846 * real'(k) / 4096.0);
    if (v_s >= 0.0) begin
      return $rtoi(v_s + 0.5);
    end else begin
      return -$rtoi(0.5 - v_s);
    end
  endfunction

endpackage

// File: rtl/sin_s11_s11_pipe_rom.sv
// Synchronous-read sine table: 1024x11 quarter wave, or 4096x12 full wave under SIN_FULL_TABLE_EN.
// Contents are generated at elaboration from f_sin_q.
module sin_quarter_rom
  import sin_s11_pkg::*;
(
  input  logic                CK_i,
  input  logic                RST_i,
  input  logic [C_ROM_AW-1:0] i_addr,
  output logic [C_ROM_DW-1:0] o_data
);

  localparam int C_DEPTH = 1 << C_ROM_AW;

  logic [C_ROM_DW-1:0] w_rom [C_DEPTH];
  logic [C_ROM_DW-1:0] r_data;

  for (genvar g = 0; g < C_DEPTH; g++) begin : g_tbl
    assign w_rom[g] = C_ROM_DW'(f_sin_q(g));
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      r_data <= '0;
    end else begin
      r_data <= w_rom[i_addr];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/sin_s11_s11_pipe.sv
// Three-stage pipelined sine generator: 12-bit phase in, signed 12-bit sine (+/-2047) out.
// Build option: SIN_FULL_TABLE_EN replaces quarter-wave mirroring with a direct full-wave lookup.
module sin_s11_s11_pipe
  import sin_s11_pkg::*;
#(
  parameter int C_B_W = 1
) (
  input  logic               CK_i,
  input  logic               RST_i,
  input  logic               CK_EE_i,
  input  logic [11:0]        DATs_i,
  input  logic [C_B_W-1:0]   B_IN_DAT_DLYs_i,
  output logic [11:0]        SINs_o,
  output logic               DONE_o,
  output logic [C_B_W-1:0]   B_OUT_DAT_DLYs_o
);

  logic [C_ROM_AW-1:0] r_addr1;
  logic [C_ROM_DW-1:0] w_rom_data;
  logic [11:0]         r_sin;
  logic [C_LAT-1:0]    r_done_sr;
  logic [C_B_W-1:0]    r_b_sr [C_LAT];

  sin_quarter_rom u_rom (
    .CK_i   (CK_i),
    .RST_i  (RST_i),
    .i_addr (r_addr1),
    .o_data (w_rom_data)
  );

`ifdef SIN_FULL_TABLE_EN

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      r_addr1 <= '0;
      r_sin   <= '0;
    end else begin
      r_addr1 <= DATs_i;
      r_sin   <= w_rom_data;
    end
  end

`else

  quad_e       w_quad;
  logic [9:0]  w_r;
  logic        w_q_odd;
  logic [9:0]  w_addr;
  logic        w_peak;
  quad_e       r_quad1;
  quad_e       r_quad2;
  logic        r_peak1;
  logic        r_peak2;
  logic [10:0] w_mag;
  logic        w_neg;

  assign w_quad  = quad_e'(DATs_i[11:10]);
  assign w_r     = DATs_i[9:0];
  assign w_q_odd = (w_quad == Q_II) || (w_quad == Q_IV);
  // Odd quadrants read Q[1024-r]; r=0 there is the peak, which lies outside the table.
  assign w_addr  = w_q_odd ? (10'd0 - w_r) : w_r;
  assign w_peak  = w_q_odd && (w_r == 10'd0);

  assign w_mag   = r_peak2 ? C_Q_PEAK : w_rom_data;
  assign w_neg   = (r_quad2 == Q_III) || (r_quad2 == Q_IV);

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      r_addr1 <= '0;
      r_quad1 <= Q_I;
      r_peak1 <= 1'b0;
      r_quad2 <= Q_I;
      r_peak2 <= 1'b0;
      r_sin   <= '0;
    end else begin
      r_addr1 <= w_addr;
      r_quad1 <= w_quad;
      r_peak1 <= w_peak;
      r_quad2 <= r_quad1;
      r_peak2 <= r_peak1;
      r_sin   <= w_neg ? (12'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
    end
  end

`endif

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      r_done_sr <= '0;
      for (int i = 0; i < C_LAT; i++) begin
        r_b_sr[i] <= '0;
      end
    end else begin
      r_done_sr <= {r_done_sr[C_LAT-2:0], CK_EE_i};
      r_b_sr[0] <= B_IN_DAT_DLYs_i;
      for (int i = 1; i < C_LAT; i++) begin
        r_b_sr[i] <= r_b_sr[i-1];
      end
    end
  end

  assign SINs_o           = r_sin;
  assign DONE_o           = r_done_sr[C_LAT-1];
  assign B_OUT_DAT_DLYs_o = r_b_sr[C_LAT-1];

endmodule

// File: tb/tb_sin_s11_s11_pipe.sv
// Scoreboard bench for sin_s11_s11_pipe: expectations queued at drive time, compared 3 clocks later.
module tb_sin_s11_s11_pipe;

  localparam int BW = 4;

  logic          CK_i = 1'b0;
  logic          RST_i;
  logic          CK_EE_i;
  logic [11:0]   DATs_i;
  logic [BW-1:0] b_in;
  logic [11:0]   SINs_o;
  logic          DONE_o;
  logic [BW-1:0] b_out;

  typedef struct {
    int sin;
    int done;
    int b;
    int p;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   outs [4096];

  sin_s11_s11_pipe #(.C_B_W(BW)) dut (
    .CK_i             (CK_i),
    .RST_i            (RST_i),
    .CK_EE_i          (CK_EE_i),
    .DATs_i           (DATs_i),
    .B_IN_DAT_DLYs_i  (b_in),
    .SINs_o           (SINs_o),
    .DONE_o           (DONE_o),
    .B_OUT_DAT_DLYs_o (b_out)
  );

  always #5 CK_i = ~CK_i;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int golden(input int p);
    real v;
    v = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(p & 4095) / 4096.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else return -$rtoi(0.5 - v);
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.sin = 0; e.done = 0; e.b = 0; e.p = -1;
    return e;
  endfunction

  // Called at a falling edge: check the output due now, drive the next input, queue its expectation.
  task automatic step(input logic rst, input logic ee, input int p, input int b, input int exp_sin);
    exp_t e;
    int   obs;
    if (sb.size() == 3) begin
      e   = sb.pop_front();
      obs = int'($signed(SINs_o));
      chk("sin", obs, e.sin);
      chk("done", int'(DONE_o), e.done);
      chk("bout", int'(b_out), e.b);
      if (e.p >= 0) outs[e.p] = obs;
    end
    RST_i   = rst;
    CK_EE_i = ee;
    DATs_i  = p[11:0];
    b_in    = b[BW-1:0];
    if (rst) begin
      sb.delete();
      repeat (3) sb.push_back(zero_exp());
    end else begin
      e.sin  = exp_sin;
      e.done = int'(ee);
      e.b    = b & ((1 << BW) - 1);
      e.p    = p & 4095;
      sb.push_back(e);
    end
    @(negedge CK_i);
  endtask

  int dir_p [10] = '{0, 1, 512, 1023, 1024, 1536, 2048, 2560, 3072, 4095};
  int dir_e [10] = '{0, 3, 1447, 2047, 2047, 1447, 0, -1447, -2047, -3};
  int ee_pat [4] = '{1, 0, 1, 1};

  initial begin
    int mn;
    int mx;
    RST_i   = 1'b1;
    CK_EE_i = 1'b0;
    DATs_i  = '0;
    b_in    = '0;
    for (int i = 0; i < 4096; i++) outs[i] = 99999;
    repeat (3) sb.push_back(zero_exp());
    @(posedge CK_i);
    @(negedge CK_i);
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, dir_p[i], i, dir_e[i]);

    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 0; p < 4096; p++) step(1'b0, 1'b1, p, p, golden(p));
    end

    for (int i = 0; i < 4; i++) step(1'b0, ee_pat[i][0], 100 + i, 5 + i, golden(100 + i));

    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 200 + i, i, golden(200 + i));
    step(1'b1, 1'b1, 777, 9, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 300 + i, 10 + i, golden(300 + i));

    step(1'b0, 1'b1, -2048, 1, 0);
    step(1'b0, 1'b1, 2048, 2, 0);
    step(1'b0, 1'b1, -1, 3, -3);
    step(1'b0, 1'b1, 4095, 4, -3);
    repeat (3) step(1'b0, 1'b0, 0, 0, 0);

    chk("sym0", outs[0], 0);
    for (int p = 1; p < 4096; p++) chk("sym", outs[p], -outs[4096 - p]);
    mn = 99999;
    mx = -99999;
    for (int p = 0; p < 4096; p++) begin
      if (outs[p] < mn) mn = outs[p];
      if (outs[p] > mx) mx = outs[p];
    end
    chk("min", mn, -2047);
    chk("max", mx, 2047);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
